// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: width, funct3 codes,
// ALU control encodings, FSM state encoding and operand-sign helpers.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // MUL only needs the low word, so it is computed on raw operands.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M sequencer sharing the core ALU (ADD/SUB) for shift-add multiply and
// restoring divide. The divide datapath is present only when MULDIV_DIV_EN is defined.
module alu_muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    output logic            busy,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_out,
    output logic [2:0]      dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where resp_valid && resp_ready, and
    // resp_valid/resp_data/resp_err hold steady until then.

    state_e             state_q, state_d;
    logic [2:0]         f3_q;
    logic               sa_q, sb_q;
    logic [XLEN-1:0]    op_a_q, op_b_q;
    logic [XLEN-1:0]    hi_q, lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               resp_valid_q, resp_err_q;
    logic [XLEN-1:0]    resp_data_q;

    logic               accept, last_iter, neg_a, special, special_err;
    logic               mul_carry, mulh_op, fix_neg;
    logic [XLEN-1:0]    b_mag, mul_sum, fix_raw, fix_result, special_data;

    assign accept     = req_valid && (state_q == ST_IDLE);
    assign last_iter  = (cnt_q == CNT_W'(XLEN - 1));
    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign dbg_state  = state_q;

`ifdef MULDIV_DIV_EN
    logic               div_by_zero, div_ovf, div_take;
    logic [XLEN-1:0]    rem_shift;

    assign div_by_zero  = (op_b_q == '0);
    assign div_ovf      = ((f3_q == F3_DIV) || (f3_q == F3_REM)) &&
                          (op_a_q == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_q == '1);
    // A zero divisor leaves the dividend raw so REM/REMU can return it untouched.
    assign neg_a        = sa_q && !(f3_q[2] && div_by_zero);
    assign special      = f3_q[2] && (div_by_zero || div_ovf);
    assign special_data = div_by_zero ? (f3_q[1] ? op_a_q : '1)
                                      : (f3_q[1] ? '0 : op_a_q);
    assign special_err  = 1'b0;
    // Remainder lives in hi_q and the quotient/dividend in lo_q while dividing.
    assign rem_shift    = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign div_take     = hi_q[XLEN-1] || (rem_shift >= op_b_q);
`else
    assign neg_a        = sa_q;
    assign special      = f3_q[2];
    assign special_data = '0;
    assign special_err  = 1'b1;
`endif

    assign b_mag     = sb_q ? alu_out : op_b_q;
    assign mul_sum   = lo_q[0] ? alu_out : hi_q;
    assign mul_carry = lo_q[0] && (alu_out < hi_q);
    assign mulh_op   = !f3_q[2] && (f3_q[1:0] != 2'b00);
    assign fix_raw   = ((f3_q == F3_MUL) || (f3_q[2:1] == 2'b10)) ? lo_q : hi_q;
    assign fix_neg   = (f3_q[2] && f3_q[1]) ? sa_q : (sa_q ^ sb_q);
    assign fix_result = fix_neg ? alu_out : fix_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_PREP;
            ST_PREP: begin
                if (!cnt_q[0]) begin
                    if (neg_a) begin
                        alu_b    = op_a_q;
                        alu_ctrl = ALU_SUB;
                    end
                end else begin
                    if (sb_q) begin
                        alu_b    = op_b_q;
                        alu_ctrl = ALU_SUB;
                    end
                    state_d = special ? ST_DONE : ST_ITER;
                end
            end
            ST_ITER: begin
`ifdef MULDIV_DIV_EN
                if (f3_q[2]) begin
                    alu_a    = rem_shift;
                    alu_b    = op_b_q;
                    alu_ctrl = ALU_SUB;
                end else
`endif
                if (lo_q[0]) begin
                    alu_a = hi_q;
                    alu_b = op_a_q;
                end
                if (last_iter) state_d = ST_FIX;
            end
            ST_FIX: begin
                // High-word negate: 0-hi when the low word is zero, else -1-hi (= ~hi).
                alu_a    = (mulh_op && (lo_q != '0)) ? '1 : '0;
                alu_b    = fix_raw;
                alu_ctrl = ALU_SUB;
                state_d  = ST_DONE;
            end
            ST_DONE: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q         <= '0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        f3_q   <= req_funct3;
                        op_a_q <= req_a;
                        op_b_q <= req_b;
                        sa_q   <= req_a[XLEN-1] && a_is_signed(req_funct3);
                        sb_q   <= req_b[XLEN-1] && b_is_signed(req_funct3);
                        cnt_q  <= '0;
                    end
                end
                ST_PREP: begin
                    if (!cnt_q[0]) begin
                        if (neg_a) op_a_q <= alu_out;
                        cnt_q <= CNT_W'(1);
                    end else begin
                        cnt_q  <= '0;
                        op_b_q <= b_mag;
                        hi_q   <= '0;
                        lo_q   <= f3_q[2] ? op_a_q : b_mag;
                        if (special) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= special_data;
                            resp_err_q   <= special_err;
                        end
                    end
                end
                ST_ITER: begin
                    if (!last_iter) cnt_q <= cnt_q + CNT_W'(1);
`ifdef MULDIV_DIV_EN
                    if (f3_q[2]) begin
                        hi_q <= div_take ? alu_out : rem_shift;
                        lo_q <= {lo_q[XLEN-2:0], div_take};
                    end else
`endif
                    begin
                        hi_q <= {mul_carry, mul_sum[XLEN-1:1]};
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                end
                ST_FIX: begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= fix_result;
                    resp_err_q   <= 1'b0;
                end
                ST_DONE: if (resp_ready) resp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
